// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult_pkg;
  localparam int MULT_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;
endpackage

// File: rtl/fh_without_carry_adder_32_bits.sv
// Combinational 32-bit ripple-carry adder; the carry out of bit 31 is dropped.
module fh_without_carry_adder_32_bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  always_comb begin
    logic v_c;
    v_c = 1'b0;
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ v_c;
      v_c    = (a[i] & b[i]) | (v_c & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/shift_add_mult_32.sv
// Sequential 32x32 shift-and-add multiplier, low 32 product bits, valid/ready.
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module shift_add_mult_32
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod,
  output logic             busy
);
  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // the producer holds data stable while valid is high and ready is low.

  mult_state_e      r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sum;
  logic             w_finish;

  fh_without_carry_adder_32_bits u_adder (
    .a   (r_acc),
    .b   (r_mcand),
    .sum (w_sum)
  );

`ifdef MULT_EARLY_TERM_EN
  // Post-shift multiplier is zero: no further partial products can contribute.
  assign w_finish = (r_cnt == CNT_W'(MULT_W - 1)) || (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_finish = (r_cnt == CNT_W'(MULT_W - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand  <= in_a;
            r_mplier <= in_b;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef MULT_EARLY_TERM_EN
            r_state  <= (in_b == '0) ? DONE : BUSY;
`else
            r_state  <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (r_mplier[0]) r_acc <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_finish) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign out_prod  = r_acc;
endmodule

// File: tb/tb_shift_add_mult_32.sv
// Scoreboard bench for shift_add_mult_32: directed operand pairs, expected products queued at accept.
module tb_shift_add_mult_32;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;
  logic        busy;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  int          lat_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          rand_en = 0;
  logic        prev_ov = 1'b0;

  shift_add_mult_32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    int m;
    if (b == 32'd0) return 1;
    m = 0;
    for (int i = 0; i < 32; i++) if (b[i]) m = i;
    return 1 + m;
`else
    return 32;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: present operands, push expectation at the accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    bit got;
    got = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(p);
        lat_q.push_back(exp_lat(b));
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        got = 1;
      end else begin
        @(posedge clk);
        #1;
        if (rand_en) out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: a=%h b=%h never accepted", a, b);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out_valid(input string name);
    bit seen;
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: out_valid never rose", name);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0 || lat_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL latency: out_valid rose with no accepted operation");
        end else begin
          check("latency", 32'(cyc - acc_q.pop_front()), 32'(lat_q.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL product: unexpected beat %h", out_prod);
        end else begin
          check("product", out_prod, exp_q.pop_front());
        end
      end
    end
    prev_ov = out_valid;
  end

  logic [31:0] tab_a[14] = '{32'h00000003, 32'hFFFFFFFF, 32'h00010000, 32'h00000007,
                             32'h00001234, 32'h00000055, 32'h00000001, 32'hFFFFFFFF,
                             32'h12345678, 32'h0000FFFF, 32'h80000000, 32'hDEADBEEF,
                             32'h00010001, 32'hFFFFFFFF};
  logic [31:0] tab_b[14] = '{32'h00000005, 32'hFFFFFFFF, 32'h00010000, 32'h00000006,
                             32'h00000002, 32'h00000000, 32'h80000000, 32'h00000002,
                             32'h00000010, 32'h0000FFFF, 32'h00000003, 32'h00000001,
                             32'h00010001, 32'h80000000};
  logic [31:0] tab_p[14] = '{32'h0000000F, 32'h00000001, 32'h00000000, 32'h0000002A,
                             32'h00002468, 32'h00000000, 32'h80000000, 32'hFFFFFFFE,
                             32'h23456780, 32'hFFFE0001, 32'h80000000, 32'hDEADBEEF,
                             32'h00020001, 32'h80000000};

  initial begin
    bit drained;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_prod", out_prod, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 3x5 with out_ready high; in_ready back one edge after out_valid
    issue(32'd3, 32'd5, 32'h0000000F);
    #1;
    check("busy_after_accept", 32'(busy), 32'(exp_lat(32'd5) > 1));
    wait_out_valid("first_op");
    @(negedge clk);
    check("in_ready_return", 32'(in_ready), 32'd1);
    check("out_valid_dropped", 32'(out_valid), 32'd0);
    check("out_prod_held_idle", out_prod, 32'h0000000F);
    @(posedge clk);
    #1;

    // backpressure: DONE held, new operands offered but not taken
    out_ready = 1'b0;
    issue(32'h0000000B, 32'h0000000D, 32'h0000008F);
    wait_out_valid("backpressure");
    in_a = 32'd9;
    in_b = 32'd9;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_prod", out_prod, 32'h0000008F);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(32'd9, 32'd9, 32'h00000051);
    wait_out_valid("after_bp");
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of an operation
    issue(32'd3, 32'h80000001, 32'h80000003);
    repeat (10) @(posedge clk);
    #2;
    check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_prod", out_prod, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(32'd7, 32'd6, 32'h0000002A);
    wait_out_valid("after_rst");
    @(posedge clk);
    #1;

    // directed table back to back with randomly toggled out_ready
    rand_en = 1;
    for (int i = 0; i < 14; i++) issue(tab_a[i], tab_b[i], tab_p[i]);
    rand_en = 0;
    out_ready = 1'b1;

    drained = 0;
    for (int t = 0; t < 200 && !drained; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) drained = 1;
    end
    if (!drained) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d products never delivered", exp_q.size());
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
